// File: rtl/ntt_forward_stream.sv
// Streaming forward negacyclic NTT (Dilithium): load N words, run an in-place
// Cooley-Tukey transform at one butterfly per cycle, then stream the result out.

module mod_mult #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned Q               = 8380417,
  parameter int unsigned REDUCTION_TYPE  = 0,
  parameter int unsigned PIPELINE_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned   PW = 2 * WIDTH;
  localparam int unsigned   QB = $clog2(Q);
  localparam int unsigned   BK = 2 * QB + 2;
  localparam logic [PW-1:0] BM = PW'((128'd1 << BK) / 128'(Q));

  function automatic logic [31:0] qinv_neg();
    logic [31:0] x;
    x = 32'(Q);
    for (int unsigned i = 0; i < 5; i++) x = x * (32'd2 - 32'(Q) * x);
    return 32'd0 - x;
  endfunction

  localparam logic [31:0] QINV_NEG = qinv_neg();

  logic [PW-1:0]    prod, bq, br, mu, red;
  logic [2*PW-1:0]  bwide;
  logic [31:0]      mm;
  logic [WIDTH-1:0] pipe [PIPELINE_STAGES];

  // Montgomery (R = 2^32) returns a*b*R^-1; callers pre-scale b by R.
  always_comb begin
    prod  = PW'(a) * PW'(b);
    bwide = (2*PW)'(prod) * (2*PW)'(BM);
    bq    = PW'(bwide >> BK);
    br    = prod - bq * PW'(Q);
    if (br >= PW'(Q)) br = br - PW'(Q);
    if (br >= PW'(Q)) br = br - PW'(Q);
    mm    = prod[31:0] * QINV_NEG;
    mu    = (prod + PW'(mm) * PW'(Q)) >> 32;
    if (mu >= PW'(Q)) mu = mu - PW'(Q);
    case (REDUCTION_TYPE)
      1:       red = br;
      2:       red = mu;
      default: red = prod % PW'(Q);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPELINE_STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= WIDTH'(red);
      for (int unsigned i = 1; i < PIPELINE_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign result = pipe[PIPELINE_STAGES-1];
endmodule

module ntt_forward_stream #(
  parameter int unsigned N              = 256,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 8380417,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned REDUCTION_TYPE = 0,
  parameter int unsigned MULT_PIPELINE  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             range_err
);
  localparam int unsigned    LOGN    = ADDR_WIDTH;
  localparam int unsigned    HALF    = N / 2;
  localparam int unsigned    STAGE_W = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int unsigned    BUB_W   = (MULT_PIPELINE > 1) ? $clog2(MULT_PIPELINE) : 1;
  localparam logic [WIDTH:0] QX      = (WIDTH+1)'(Q);

  function automatic logic [63:0] mulmod(logic [63:0] x, logic [63:0] y);
    return (x * y) % 64'(Q);
  endfunction

  function automatic logic [63:0] powmod(logic [63:0] base, int unsigned e);
    logic [63:0] r, bb;
    int unsigned k;
    r  = 64'd1;
    bb = base;
    k  = e;
    while (k != 0) begin
      if ((k & 32'd1) != 0) r = mulmod(r, bb);
      bb = mulmod(bb, bb);
      k  = k >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned bitrev(int unsigned v, int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 32'd1);
    return r;
  endfunction

  // 1753 is a primitive 512th root of unity mod Q; scale it down to a 2N-th root.
  function automatic logic [WIDTH-1:0] twiddle_val(int unsigned k);
    logic [63:0] z;
    z = powmod(powmod(64'd1753, 256 / N), bitrev(k, LOGN));
    if (REDUCTION_TYPE == 2) z = (z << 32) % 64'(Q);
    return WIDTH'(z);
  endfunction

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   in_cnt, out_cnt, rd_addr;
  logic                    rd_all;
  logic [STAGE_W-1:0]      stage;
  logic [ADDR_WIDTH-2:0]   bfly;
  logic                    in_bubble;
  logic [BUB_W-1:0]        bub_cnt;
  logic [WIDTH-1:0]        mem [N];
  logic [WIDTH-1:0]        twiddle_rom [N];

  logic                    load_fire, out_fire, issue;
  logic [WIDTH-1:0]        in_store;
  logic [ADDR_WIDTH-1:0]   jj, len, lo, bf_a0, bf_a1, bf_z;
  logic [WIDTH-1:0]        mult_t, wb_a;
  logic [WIDTH:0]          sum, sum_r, diff, diff_r;

  logic [MULT_PIPELINE-1:0] v_pipe;
  logic [WIDTH-1:0]         a_pipe  [MULT_PIPELINE];
  logic [ADDR_WIDTH-1:0]    a0_pipe [MULT_PIPELINE];
  logic [ADDR_WIDTH-1:0]    a1_pipe [MULT_PIPELINE];

  for (genvar k = 0; k < N; k++) begin : g_twiddle
    localparam logic [WIDTH-1:0] TW = twiddle_val(k);
    assign twiddle_rom[k] = TW;
  end

  assign load_fire = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign issue     = (state == COMPUTE) && !in_bubble;
  assign in_store  = (in_data >= WIDTH'(Q)) ? in_data - WIDTH'(Q) : in_data;

  // a0 is j with a zero bit inserted at position log2(len); zeta index is (N/2 + j) >> (LOGN-1-s).
  always_comb begin
    jj    = {1'b0, bfly};
    len   = ADDR_WIDTH'(HALF) >> stage;
    lo    = len - ADDR_WIDTH'(1);
    bf_a0 = ((jj & ~lo) << 1) | (jj & lo);
    bf_a1 = bf_a0 | len;
    bf_z  = (ADDR_WIDTH'(HALF) | jj) >> (STAGE_W'(LOGN - 1) - stage);
  end

  mod_mult #(
    .WIDTH          (WIDTH),
    .Q              (Q),
    .REDUCTION_TYPE (REDUCTION_TYPE),
    .PIPELINE_STAGES(MULT_PIPELINE)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mem[bf_a1]),
    .b     (twiddle_rom[bf_z]),
    .result(mult_t)
  );

  always_comb begin
    wb_a   = a_pipe[MULT_PIPELINE-1];
    sum    = {1'b0, wb_a} + {1'b0, mult_t};
    sum_r  = (sum >= QX) ? sum - QX : sum;
    diff   = {1'b0, wb_a} - {1'b0, mult_t};
    diff_r = diff[WIDTH] ? diff + QX : diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int unsigned i = 0; i < MULT_PIPELINE; i++) begin
        a_pipe[i]  <= '0;
        a0_pipe[i] <= '0;
        a1_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0]  <= issue;
      a_pipe[0]  <= mem[bf_a0];
      a0_pipe[0] <= bf_a0;
      a1_pipe[0] <= bf_a1;
      for (int unsigned i = 1; i < MULT_PIPELINE; i++) begin
        v_pipe[i]  <= v_pipe[i-1];
        a_pipe[i]  <= a_pipe[i-1];
        a0_pipe[i] <= a0_pipe[i-1];
        a1_pipe[i] <= a1_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v_pipe[MULT_PIPELINE-1]) begin
      mem[a0_pipe[MULT_PIPELINE-1]] <= sum_r[WIDTH-1:0];
      mem[a1_pipe[MULT_PIPELINE-1]] <= diff_r[WIDTH-1:0];
    end else if (load_fire) begin
      mem[in_cnt] <= in_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      in_cnt    <= '0;
      out_cnt   <= '0;
      rd_addr   <= '0;
      rd_all    <= 1'b0;
      stage     <= '0;
      bfly      <= '0;
      in_bubble <= 1'b0;
      bub_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (load_fire) begin
            if (in_data >= WIDTH'(Q)) range_err <= 1'b1;
            in_cnt <= in_cnt + ADDR_WIDTH'(1);
            if (in_cnt == ADDR_WIDTH'(N - 1)) begin
              state     <= COMPUTE;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              stage     <= '0;
              bfly      <= '0;
              in_bubble <= 1'b0;
              bub_cnt   <= '0;
            end
          end
        end
        COMPUTE: begin
          if (!in_bubble) begin
            if (bfly == '1) begin
              bfly      <= '0;
              in_bubble <= 1'b1;
              bub_cnt   <= '0;
            end else begin
              bfly <= bfly + (ADDR_WIDTH-1)'(1);
            end
          end else if (bub_cnt == BUB_W'(MULT_PIPELINE - 1)) begin
            in_bubble <= 1'b0;
            bub_cnt   <= '0;
            if (stage == STAGE_W'(LOGN - 1)) begin
              state   <= UNLOAD;
              done    <= 1'b1;
              rd_addr <= '0;
              rd_all  <= 1'b0;
              out_cnt <= '0;
            end else begin
              stage <= stage + STAGE_W'(1);
            end
          end else begin
            bub_cnt <= bub_cnt + BUB_W'(1);
          end
        end
        UNLOAD: begin
          // out_data is the read register: refilled whenever empty or being consumed.
          if ((!out_valid || out_ready) && !rd_all) begin
            out_data  <= mem[rd_addr];
            out_valid <= 1'b1;
            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
            if (rd_addr == '1) rd_all <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (out_fire) begin
            out_cnt <= out_cnt + ADDR_WIDTH'(1);
            if (out_cnt == '1) begin
              state     <= LOAD;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              range_err <= 1'b0;
              in_cnt    <= '0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
